mips_muldiv: RTL and testbench



---
 rtl/mips_muldiv.sv | 182 ++++++++++++++++++
 tb/tb_mips_muldiv.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit with HI/LO registers.
//
// Handles MULT/MULTU/DIV/DIVU for the datapath and holds HI/LO for MFHI/MFLO and MTHI/MTLO.
// One iteration per clock. An operation takes WSIZE+1 cycles from the start edge to the done pulse.
//
// Ports:
//   clock, reset_n        - clock; synchronous active-low reset
//   start, op[1:0]        - launch (IDLE only); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_val, rt_val        - multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we, wr_data - MTHI/MTLO writes (IDLE only; start takes priority)
//   busy                  - operation in flight
//   done                  - one-cycle pulse after HI/LO were written by an operation
//   hi, lo                - HI/LO registers
//
// Configuration: define MIPS_MULDIV_DIV_EN to build the divider.
// Without it, a start with op[1]=1 is ignored.
module mips_muldiv #(
   parameter int unsigned WSIZE = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WSIZE-1:0] rs_val,
   input  logic [WSIZE-1:0] rt_val,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WSIZE-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WSIZE-1:0] hi,
   output logic [WSIZE-1:0] lo
);

   localparam int unsigned CntW = (WSIZE > 1) ? $clog2(WSIZE) : 1;
   localparam logic [CntW-1:0] LastIter = CntW'(WSIZE - 1);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e             state_q;
   logic [CntW-1:0]    cnt_q;
   logic [2*WSIZE-1:0] acc_q;      // {upper, lower}: product, or {remainder, dividend/quotient}
   logic [WSIZE-1:0]   opnd_q;     // multiplicand or divisor magnitude
   logic               neg_res_q;  // negate product / quotient in FIX
   logic               busy_q;
   logic               done_q;
   logic [WSIZE-1:0]   hi_q;
   logic [WSIZE-1:0]   lo_q;
`ifdef MIPS_MULDIV_DIV_EN
   logic               is_div_q;
   logic               neg_rem_q;
   logic               div_zero_q;
   logic [WSIZE-1:0]   dividend_q; // raw rs, returned as HI on divide by zero
`endif

   logic               is_signed;
   logic               launch;
   logic [WSIZE-1:0]   rs_abs;
   logic [WSIZE-1:0]   rt_abs;
   logic [WSIZE:0]     mul_sum;
   logic [2*WSIZE-1:0] mul_next;
   logic [2*WSIZE-1:0] prod_fix;
`ifdef MIPS_MULDIV_DIV_EN
   logic [WSIZE:0]     rem_shift;
   logic [WSIZE-1:0]   rem_diff;
   logic               rem_take;
   logic [2*WSIZE-1:0] div_next;
   logic [WSIZE-1:0]   quot_fix;
   logic [WSIZE-1:0]   rem_fix;
`endif

   always_comb begin
      is_signed = ~op[0];
      rs_abs    = (is_signed && rs_val[WSIZE-1]) ? -rs_val : rs_val;
      rt_abs    = (is_signed && rt_val[WSIZE-1]) ? -rt_val : rt_val;
`ifdef MIPS_MULDIV_DIV_EN
      launch    = start;
`else
      launch    = start & ~op[1];
`endif

      // Shift-add: add multiplicand to upper half when multiplier LSB is set, then shift right.
      mul_sum   = {1'b0, acc_q[2*WSIZE-1:WSIZE]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WSIZE-1:1]};
      prod_fix  = neg_res_q ? -acc_q : acc_q;

`ifdef MIPS_MULDIV_DIV_EN
      // Restoring step. The true difference is below the divisor when taken, so WSIZE bits hold it.
      rem_shift = acc_q[2*WSIZE-1:WSIZE-1];
      rem_take  = rem_shift >= {1'b0, opnd_q};
      rem_diff  = rem_shift[WSIZE-1:0] - opnd_q;
      div_next  = rem_take ? {rem_diff, acc_q[WSIZE-2:0], 1'b1}
                           : {rem_shift[WSIZE-1:0], acc_q[WSIZE-2:0], 1'b0};
      quot_fix  = neg_res_q ? -acc_q[WSIZE-1:0] : acc_q[WSIZE-1:0];
      rem_fix   = neg_rem_q ? -acc_q[2*WSIZE-1:WSIZE] : acc_q[2*WSIZE-1:WSIZE];
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         neg_res_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
`ifdef MIPS_MULDIV_DIV_EN
         is_div_q   <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         dividend_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (launch) begin
                  state_q   <= StCalc;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  neg_res_q <= is_signed & (rs_val[WSIZE-1] ^ rt_val[WSIZE-1]);
`ifdef MIPS_MULDIV_DIV_EN
                  is_div_q   <= op[1];
                  neg_rem_q  <= is_signed & rs_val[WSIZE-1];
                  div_zero_q <= (rt_val == '0);
                  dividend_q <= rs_val;
                  if (op[1]) begin
                     acc_q  <= {{WSIZE{1'b0}}, rs_abs};
                     opnd_q <= rt_abs;
                  end else begin
                     acc_q  <= {{WSIZE{1'b0}}, rt_abs};
                     opnd_q <= rs_abs;
                  end
`else
                  acc_q  <= {{WSIZE{1'b0}}, rt_abs};
                  opnd_q <= rs_abs;
`endif
               end else begin
                  if (hi_we) hi_q <= wr_data;
                  if (lo_we) lo_q <= wr_data;
               end
            end
            StCalc: begin
`ifdef MIPS_MULDIV_DIV_EN
               acc_q <= is_div_q ? div_next : mul_next;
`else
               acc_q <= mul_next;
`endif
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LastIter) state_q <= StFix;
            end
            StFix: begin
`ifdef MIPS_MULDIV_DIV_EN
               if (is_div_q) begin
                  lo_q <= div_zero_q ? '1 : quot_fix;
                  hi_q <= div_zero_q ? dividend_q : rem_fix;
               end else begin
                  hi_q <= prod_fix[2*WSIZE-1:WSIZE];
                  lo_q <= prod_fix[WSIZE-1:0];
               end
`else
               hi_q <= prod_fix[2*WSIZE-1:WSIZE];
               lo_q <= prod_fix[WSIZE-1:0];
`endif
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed testbench for mips_muldiv (WSIZE=32). Divide vectors run when MIPS_MULDIV_DIV_EN is
// defined; otherwise the bench checks that a divide start is ignored.
module tb_mips_muldiv;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total = 0;
   int bad   = 0;

   localparam logic [1:0] OpMult  = 2'b00;
   localparam logic [1:0] OpMultu = 2'b01;
   localparam logic [1:0] OpDiv   = 2'b10;
   localparam logic [1:0] OpDivu  = 2'b11;

   mips_muldiv #(.WSIZE(32)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .rs_val  (rs_val),
      .rt_val  (rt_val),
      .hi_we   (hi_we),
      .lo_we   (lo_we),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Drive a start in the cycle after the next negedge; returns #1 after the start edge (E0).
   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
      @(negedge clock);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      @(posedge clock);
      #1;
      start = 1'b0;
      check({tag, "_busy"}, {31'b0, busy}, 32'd1);
   endtask

   // Wait for done (bounded), then check latency (edges waited), busy low and HI/LO.
   task automatic wait_result(input string tag, input int exp_lat,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
      start_op(o, a, b, tag);
      wait_result(tag, 33, exp_hi, exp_lo);
   endtask

   initial begin
      bit saw_done;
      reset_n = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      rs_val  = '0;
      rt_val  = '0;
      hi_we   = 1'b0;
      lo_we   = 1'b0;
      wr_data = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // MTHI / MTLO
      @(negedge clock);
      hi_we = 1'b1; wr_data = 32'hDEADBEEF;
      @(negedge clock);
      hi_we = 1'b0; lo_we = 1'b1; wr_data = 32'h12345678;
      check("mthi", hi, 32'hDEADBEEF);
      @(negedge clock);
      lo_we = 1'b0;
      check("mtlo", lo, 32'h12345678);
      check("mtlo_hi_hold", hi, 32'hDEADBEEF);

      // Multiplies; each start lands in the previous done cycle (back-to-back).
      run_op(OpMult,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7");
      run_op(OpMultu, 32'hFFFFFFFD, 32'd7,        32'h00000006, 32'hFFFFFFEB, "multu_big");
      run_op(OpMult,  32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, "mult_neg_neg");
      run_op(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
      run_op(OpMult,  32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000, "mult_minneg");

      // Start + MTHI while busy are both ignored.
      start_op(OpMult, 32'd3, 32'd5, "ign");
      repeat (9) @(posedge clock);
      @(negedge clock);
      start = 1'b1; op = OpMultu; rs_val = 32'd100; rt_val = 32'd100;
      hi_we = 1'b1; wr_data = 32'hCAFEF00D;
      @(posedge clock);
      #1;
      start = 1'b0; hi_we = 1'b0;
      check("ign_hi_hold", hi, 32'h00000000 - 32'd1);
      wait_result("ign", 23, 32'h0, 32'd15);
      // No second operation may follow from the ignored start.
      @(posedge clock);
      #1;
      check("ign_idle", {31'b0, busy}, 32'd0);

`ifdef MIPS_MULDIV_DIV_EN
      run_op(OpDiv,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2");
      run_op(OpDivu, 32'd100,      32'd7,        32'd2,        32'd14,       "divu_100d7");
      run_op(OpDivu, 32'h55,       32'd0,        32'h55,       32'hFFFFFFFF, "divu_zero");
      run_op(OpDiv,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, "div_ovf");
      run_op(OpDiv,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_zero");
      run_op(OpDiv,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7dm2");
`else
      // Divide start ignored without the divider.
      @(negedge clock);
      start = 1'b1; op = OpDiv; rs_val = 32'd100; rt_val = 32'd7;
      @(posedge clock);
      #1;
      start = 1'b0;
      check("nodiv_busy", {31'b0, busy}, 32'd0);
      saw_done = 1'b0;
      repeat (36) begin
         @(posedge clock);
         #1;
         if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      end
      check("nodiv_quiet", {31'b0, saw_done}, 32'd0);
      check("nodiv_hi", hi, 32'h0);
      check("nodiv_lo", lo, 32'd15);
`endif

      // Reset in the middle of an operation discards it.
      @(negedge clock);
      hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'hA5A5A5A5;
      @(negedge clock);
      hi_we = 1'b0; lo_we = 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      start_op(OpDivu, 32'd100, 32'd7, "rst_mid");
`else
      start_op(OpMultu, 32'd100, 32'd7, "rst_mid");
`endif
      repeat (14) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      check("rst_mid_busy", {31'b0, busy}, 32'd0);
      check("rst_mid_hi", hi, 32'h0);
      check("rst_mid_lo", lo, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      check("rst_mid_nodone", {31'b0, saw_done}, 32'd0);

      // Unit still works after the mid-op reset.
      run_op(OpMultu, 32'd100, 32'd7, 32'h0, 32'd700, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
